reg_file: RTL and testbench



---
 rtl/rv32_pkg.sv | 17 +
 rtl/reg_file_init_seq.sv | 63 ++++++
 rtl/reg_file.sv | 83 ++++++++
 tb/tb_reg_file.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: datapath widths, register-file state
// encoding and the x0 index used by the decoder, hazard logic and regfile.
package rv32_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NREG       = 32;

    // Register-file lifecycle: clearing after reset, then normal operation.
    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = REG_ADDR_W'(0);

endpackage

// File: rtl/reg_file_init_seq.sv
// Post-reset clear sequencer for the register file.
// Walks x1..x31 one entry per cycle, then enters RUN and raises Ready.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   init_we     - 1 while clearing (INIT state), registered
//   init_addr   - entry being cleared this cycle, registered
//   Ready       - 1 once every entry has been cleared, registered
module reg_file_init_seq
    import rv32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_we,
    output logic [REG_ADDR_W-1:0] init_addr,
    output logic                  Ready
);

    rf_state_e             state_q, state_d;
    logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  ready_q, ready_d;

    // State register; the counter restarts at x1 since x0 has no storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_INIT;
            cnt_q   <= REG_ADDR_W'(1);
            we_q    <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            ready_q <= ready_d;
        end
    end

    // Next state: advance the clear pointer; leave INIT on the edge that clears the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        ready_d = ready_q;
        case (state_q)
            RF_INIT: begin
                cnt_d = cnt_q + REG_ADDR_W'(1);
                if (cnt_q == REG_ADDR_W'(NREG - 1)) begin
                    state_d = RF_RUN;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                end
            end
            RF_RUN: begin
            end
            default: state_d = RF_INIT;
        endcase
    end

    assign init_we   = we_q;
    assign init_addr = cnt_q;
    assign Ready     = ready_q;

endmodule

// File: rtl/reg_file.sv
// RV32I architectural register file: 2 combinational read ports, 1 write port.
// Entries are cleared by reg_file_init_seq after each reset; x0 reads zero.
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   RegWrite/Write_register/Write_data - core write port (ignored during init)
//   Read_register1/2 -> Read_data1/2  - combinational reads, optional bypass
//   Ready                          - 1 once init is complete
module reg_file
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN   = rv32_pkg::XLEN,
    parameter int unsigned NREG   = rv32_pkg::NREG,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] Write_register,
    input  logic [XLEN-1:0]       Write_data,
    input  logic [REG_ADDR_W-1:0] Read_register1,
    input  logic [REG_ADDR_W-1:0] Read_register2,
    output logic [XLEN-1:0]       Read_data1,
    output logic [XLEN-1:0]       Read_data2,
    output logic                  Ready
);

    logic [XLEN-1:0]       regs [1:NREG-1];
    logic                  init_we;
    logic [REG_ADDR_W-1:0] init_addr;
    logic                  wr_en_c;
    logic [REG_ADDR_W-1:0] wr_addr_c;
    logic [XLEN-1:0]       wr_data_c;

    reg_file_init_seq u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_we   (init_we),
        .init_addr (init_addr),
        .Ready     (Ready)
    );

    // Write source select: the clear sequencer owns the port during init.
    // rst_n gates the enable so nothing is written on a reset edge.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_addr_c = Write_register;
        wr_data_c = Write_data;
        if (init_we) begin
            wr_en_c   = rst_n;
            wr_addr_c = init_addr;
            wr_data_c = '0;
        end else begin
            wr_en_c = rst_n & RegWrite & (Write_register != REG_ZERO);
        end
    end

    // Storage has no reset; contents come from the init sweep.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            regs[wr_addr_c] <= wr_data_c;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [REG_ADDR_W-1:0] idx);
        logic [XLEN-1:0] val;
        val = '0;
        if (!Ready || idx == REG_ZERO) begin
            val = '0;
        end else if (BYPASS && RegWrite && Write_register == idx) begin
            val = Write_data;
        end else begin
            val = regs[idx];
        end
        return val;
    endfunction

    // Combinational reads; forced to zero until init completes.
    always_comb begin
        Read_data1 = read_port(Read_register1);
        Read_data2 = read_port(Read_register2);
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed + random check of reg_file, with bypass and non-bypass instances
// driven from the same stimulus.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [4:0]  Read_register1;
    logic [4:0]  Read_register2;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        ready_b, ready_n;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [0:31];

    reg_file #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .Read_register1 (Read_register1),
        .Read_register2 (Read_register2),
        .Read_data1     (rd1_b),
        .Read_data2     (rd2_b),
        .Ready          (ready_b)
    );

    reg_file #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) dut_n (
        .clk            (clk),
        .rst_n          (rst_n),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .Read_register1 (Read_register1),
        .Read_register2 (Read_register2),
        .Read_data1     (rd1_n),
        .Read_data2     (rd2_n),
        .Ready          (ready_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e1b, input logic [31:0] e2b,
                           input logic [31:0] e1n, input logic [31:0] e2n);
        #1;
        chk({tag, "_rd1_byp"},   rd1_b, e1b);
        chk({tag, "_rd2_byp"},   rd2_b, e2b);
        chk({tag, "_rd1_nobyp"}, rd1_n, e1n);
        chk({tag, "_rd2_nobyp"}, rd2_n, e2n);
    endtask

    function automatic logic [31:0] model(input logic [4:0] idx, input bit byp);
        if (idx == 5'd0) return 32'h0;
        if (byp && RegWrite && Write_register == idx) return Write_data;
        return sb[idx];
    endfunction

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            Read_register1 = 5'(i);
            Read_register2 = 5'(31 - i);
            chk_all(tag, 32'h0, 32'h0, 32'h0, 32'h0);
        end
    endtask

    task automatic init_walk(input string tag, input bit poke_x5);
        for (int i = 0; i < 31; i++) begin
            chk({tag, "_ready_low_byp"}, {31'b0, ready_b}, 32'h0);
            chk({tag, "_ready_low_nobyp"}, {31'b0, ready_n}, 32'h0);
            RegWrite = 1'b0;
            if (poke_x5 && i == 10) begin
                RegWrite       = 1'b1;
                Write_register = 5'd5;
                Write_data     = 32'hDEADBEEF;
            end
            Read_register1 = 5'd5;
            Read_register2 = 5'd3;
            chk_all({tag, "_init_read"}, 32'h0, 32'h0, 32'h0, 32'h0);
            tick();
        end
        RegWrite = 1'b0;
        chk({tag, "_ready_high_byp"}, {31'b0, ready_b}, 32'h1);
        chk({tag, "_ready_high_nobyp"}, {31'b0, ready_n}, 32'h1);
    endtask

    initial begin
        logic [4:0] prev_wr;
        rst_n          = 1'b0;
        RegWrite       = 1'b0;
        Write_register = 5'd0;
        Write_data     = 32'h0;
        Read_register1 = 5'd0;
        Read_register2 = 5'd0;

        // Reset held for 3 edges
        repeat (3) tick();
        chk("reset_ready", {31'b0, ready_b}, 32'h0);
        Read_register1 = 5'd1;
        Read_register2 = 5'd2;
        chk_all("reset_read", 32'h0, 32'h0, 32'h0, 32'h0);

        // Release and walk E0..E30; stray write to x5 during init must vanish
        rst_n = 1'b1;
        init_walk("init", 1'b1);
        check_all_zero("post_init");

        // Basic write/read
        RegWrite = 1'b1; Write_register = 5'd1;  Write_data = 32'h0000_0001; tick();
        Write_register = 5'd31; Write_data = 32'hFFFF_FFFF; tick();
        RegWrite = 1'b0; Read_register1 = 5'd1; Read_register2 = 5'd31;
        chk_all("basic", 32'h1, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF);

        // x0 protection, same cycle and next
        RegWrite = 1'b1; Write_register = 5'd0; Write_data = 32'h1234_5678;
        Read_register1 = 5'd0; Read_register2 = 5'd0;
        chk_all("x0_same", 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        RegWrite = 1'b0;
        chk_all("x0_next", 32'h0, 32'h0, 32'h0, 32'h0);

        // Bypass: x7 = A, then write B while reading x7 on both ports
        RegWrite = 1'b1; Write_register = 5'd7; Write_data = 32'hA; tick();
        Write_data = 32'hB; Read_register1 = 5'd7; Read_register2 = 5'd7;
        chk_all("bypass_same", 32'hB, 32'hB, 32'hA, 32'hA);
        tick();
        RegWrite = 1'b0;
        chk_all("bypass_next", 32'hB, 32'hB, 32'hB, 32'hB);

        // Fill x1..x31 with own index
        for (int i = 1; i < 32; i++) begin
            RegWrite = 1'b1; Write_register = 5'(i); Write_data = 32'(i);
            tick();
        end
        RegWrite = 1'b0;
        Read_register1 = 5'd3; Read_register2 = 5'd30;
        chk_all("fill", 32'd3, 32'd30, 32'd3, 32'd30);

        // Reset for one edge while writing x3
        rst_n = 1'b0; RegWrite = 1'b1; Write_register = 5'd3; Write_data = 32'h55;
        tick();
        rst_n = 1'b1; RegWrite = 1'b0;
        init_walk("midreset", 1'b0);
        check_all_zero("post_midreset");

        // Random regression against a scoreboard
        for (int i = 0; i < 32; i++) sb[i] = 32'h0;
        prev_wr = 5'd1;
        for (int c = 0; c < 10000; c++) begin
            RegWrite = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) Write_register = prev_wr;
            else Write_register = 5'($urandom_range(0, 31));
            Write_data = $urandom;
            case ($urandom_range(0, 2))
                0:       Read_register1 = Write_register;
                1:       Read_register1 = prev_wr;
                default: Read_register1 = 5'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 2))
                0:       Read_register2 = Write_register;
                1:       Read_register2 = prev_wr;
                default: Read_register2 = 5'($urandom_range(0, 31));
            endcase
            chk_all("random", model(Read_register1, 1'b1), model(Read_register2, 1'b1),
                    model(Read_register1, 1'b0), model(Read_register2, 1'b0));
            tick();
            if (RegWrite && Write_register != 5'd0) sb[Write_register] = Write_data;
            prev_wr = Write_register;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
